// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - execute-stage ALU with multi-cycle multiply/divide unit and HI/LO registers
module alu_mdu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  input  logic [2:0]       md_op,
  input  logic             md_start,
  output logic             md_busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SW   = $clog2(WIDTH);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               op_signed;

  logic [SW-1:0]      sh;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;
  logic               neg_a;
  logic               neg_b;
  logic               div_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   mag_q;
  logic [WIDTH-1:0]   mag_r;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign sh   = srca[SW-1:0];
  assign zero = (srca == srcb);

  // ALU function select; unused encodings fall back to add
  always_comb begin
    alu_result = srca + srcb;
    case (alu_op)
      4'd1:  alu_result = srca - srcb;
      4'd2:  alu_result = srca | srcb;
      4'd3:  alu_result = {srcb[15:0], {(WIDTH-16){1'b0}}};
      4'd4:  alu_result = srca & srcb;
      4'd5:  alu_result = srca ^ srcb;
      4'd6:  alu_result = ~(srca | srcb);
      4'd7:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      4'd8:  alu_result = {{(WIDTH-1){1'b0}}, (srca < srcb)};
      4'd9:  alu_result = srcb << sh;
      4'd10: alu_result = srcb >> sh;
      4'd11: alu_result = $unsigned($signed(srcb) >>> sh);
      4'd12: alu_result = hi;
      4'd13: alu_result = lo;
      default: alu_result = srca + srcb;
    endcase
  end

  // MDU datapath on latched operands: sign-extended product, sign-magnitude divide
  always_comb begin
    ext_a    = op_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    ext_b    = op_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    product  = ext_a * ext_b;
    neg_a    = op_signed & op_a[WIDTH-1];
    neg_b    = op_signed & op_b[WIDTH-1];
    div_zero = (op_b == '0);
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    mag_q    = div_zero ? '0 : mag_a / mag_b;
    mag_r    = div_zero ? '0 : mag_a % mag_b;
    quo      = div_zero ? '1 : ((neg_a ^ neg_b) ? -mag_q : mag_q);
    rem      = div_zero ? op_a : (neg_a ? -mag_r : mag_r);
  end

  // MDU control: accept ops in IDLE, count down while busy, commit HI/LO on the last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      md_busy   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            case (md_op)
              3'd1, 3'd2: begin
                op_a      <= srca;
                op_b      <= srcb;
                op_signed <= (md_op == 3'd1);
                md_busy   <= 1'b1;
                count     <= CW'(MUL_CYCLES - 1);
                state     <= MUL;
              end
              3'd3, 3'd4: begin
                op_a      <= srca;
                op_b      <= srcb;
                op_signed <= (md_op == 3'd3);
                md_busy   <= 1'b1;
                count     <= CW'(DIV_CYCLES - 1);
                state     <= DIV;
              end
              3'd5:    hi <= srca;
              3'd6:    lo <= srca;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (count == '0) begin
            hi      <= product[2*WIDTH-1:WIDTH];
            lo      <= product[WIDTH-1:0];
            md_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DIV: begin
          if (count == '0) begin
            hi      <= rem;
            lo      <= quo;
            md_busy <= 1'b0;
            state   <= IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - self-checking bench for alu_mdu against a behavioural model
module tb_alu_mdu;

  logic        clk;
  logic        rst_n;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        zero;
  logic [2:0]  md_op;
  logic        md_start;
  logic        md_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks;
  int n_errors;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  alu_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n), .srca(srca), .srcb(srcb), .alu_op(alu_op),
    .alu_result(alu_result), .zero(zero), .md_op(md_op), .md_start(md_start),
    .md_busy(md_busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU computed from plain arithmetic on the operand values
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] h, input logic [31:0] l);
    int unsigned s;
    logic [31:0] fill;
    s = a % 32;
    case (op)
      4'd1:  return a - b;
      4'd2:  return a | b;
      4'd3:  return b * 32'h0001_0000;
      4'd4:  return a & b;
      4'd5:  return a ^ b;
      4'd6:  return ~(a | b);
      4'd7:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd8:  return (a < b) ? 32'd1 : 32'd0;
      4'd9:  return b << s;
      4'd10: return b >> s;
      4'd11: begin
        fill = b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
        return (b >> s) | fill;
      end
      4'd12: return h;
      4'd13: return l;
      default: return a + b;
    endcase
  endfunction

  // Reference MDU using 64-bit integer arithmetic
  task automatic md_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ch, input logic [31:0] cl,
                        output logic [31:0] nh, output logic [31:0] nl, output int cyc);
    longint sa, sb, p;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
    nh = ch; nl = cl; cyc = 0;
    case (op)
      3'd1: begin p = sa * sb; nh = p[63:32]; nl = p[31:0]; cyc = 5; end
      3'd2: begin p = longint'({32'h0, a}) * longint'({32'h0, b}); nh = p[63:32]; nl = p[31:0]; cyc = 5; end
      3'd3: begin
        cyc = 10;
        if (b == 0) begin nl = 32'hFFFF_FFFF; nh = a; end
        else begin p = sa / sb; nl = p[31:0]; p = sa % sb; nh = p[31:0]; end
      end
      3'd4: begin
        cyc = 10;
        if (b == 0) begin nl = 32'hFFFF_FFFF; nh = a; end
        else begin nl = a / b; nh = a % b; end
      end
      3'd5: nh = a;
      3'd6: nl = a;
      default: ;
    endcase
  endtask

  // Issue one md op, scramble operands while busy, report busy length and final HI/LO
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic [31:0] h, output logic [31:0] l);
    srca = a; srcb = b; md_op = op; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0; md_op = 3'd0;
    cyc = 0;
    while (md_busy && cyc < 100) begin
      srca = $urandom; srcb = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    h = hi; l = lo;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; srca = 32'd1; srcb = 32'd2; alu_op = 4'd0; md_op = 3'd0; md_start = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    n_checks++; if (hi !== 32'h0) begin n_errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_checks++; if (md_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", md_busy); end
    n_checks++; if (alu_result !== 32'd3) begin n_errors++; $display("FAIL reset_alu: got %h want 3", alu_result); end
    @(posedge clk); #1 rst_n = 1'b1;
    exp_hi = 0; exp_lo = 0;
  endtask

  task automatic test_alu_directed();
    logic [3:0]  ops [6]  = '{4'd1, 4'd1, 4'd7, 4'd8, 4'd11, 4'd3};
    logic [31:0] as  [6]  = '{32'd5, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4, 32'd0};
    logic [31:0] bs  [6]  = '{32'd7, 32'd9, 32'd1, 32'd1, 32'h8000_0000, 32'h1234};
    logic [31:0] rs  [6]  = '{32'hFFFF_FFFE, 32'd0, 32'd1, 32'd0, 32'hF800_0000, 32'h1234_0000};
    logic        zs  [6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      alu_op = ops[i]; srca = as[i]; srcb = bs[i];
      #1;
      n_checks++;
      if (alu_result !== rs[i]) begin n_errors++; $display("FAIL alu_dir[%0d]: got %h want %h", i, alu_result, rs[i]); end
      n_checks++;
      if (zero !== zs[i]) begin n_errors++; $display("FAIL zero_dir[%0d]: got %b want %b", i, zero, zs[i]); end
    end
  endtask

  task automatic test_alu_random();
    logic [31:0] e;
    for (int i = 0; i < 300; i++) begin
      alu_op = 4'($urandom_range(0, 13));
      if (alu_op == 4'd12 || alu_op == 4'd13) alu_op = alu_op + 4'd2;
      srca = $urandom; srcb = (i % 7 == 0) ? srca : $urandom;
      #1;
      e = alu_ref(alu_op, srca, srcb, exp_hi, exp_lo);
      n_checks++;
      if (alu_result !== e) begin n_errors++; $display("FAIL alu_rand op=%0d a=%h b=%h: got %h want %h", alu_op, srca, srcb, alu_result, e); end
      n_checks++;
      if (zero !== (srca == srcb)) begin n_errors++; $display("FAIL zero_rand: got %b want %b", zero, srca == srcb); end
    end
  endtask

  task automatic test_mdu_directed();
    logic [2:0]  ops [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3};
    logic [31:0] as  [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'd7, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] ehs [5] = '{32'hFFFF_FFFF, 32'd6, 32'hFFFF_FFFF, 32'd7, 32'd0};
    logic [31:0] els [5] = '{32'hFFFF_FFEB, 32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
    int          ecs [5] = '{5, 5, 10, 10, 10};
    int cyc; logic [31:0] h, l;
    for (int i = 0; i < 5; i++) begin
      run_md(ops[i], as[i], bs[i], cyc, h, l);
      n_checks++; if (cyc !== ecs[i]) begin n_errors++; $display("FAIL md_dir_busy[%0d]: got %0d cycles want %0d", i, cyc, ecs[i]); end
      n_checks++; if (h !== ehs[i]) begin n_errors++; $display("FAIL md_dir_hi[%0d]: got %h want %h", i, h, ehs[i]); end
      n_checks++; if (l !== els[i]) begin n_errors++; $display("FAIL md_dir_lo[%0d]: got %h want %h", i, l, els[i]); end
      exp_hi = ehs[i]; exp_lo = els[i];
    end
  endtask

  task automatic test_mdu_random();
    int cyc, ecyc; logic [2:0] op; logic [31:0] a, b, h, l, eh, el;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(1, 6));
      a = $urandom; b = $urandom;
      if (i % 5 == 0) b = 0;
      if (i % 7 == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      if (i % 4 == 1) b = b >> $urandom_range(0, 31);
      md_ref(op, a, b, exp_hi, exp_lo, eh, el, ecyc);
      run_md(op, a, b, cyc, h, l);
      n_checks++; if (cyc !== ecyc) begin n_errors++; $display("FAIL md_rand_busy op=%0d: got %0d want %0d", op, cyc, ecyc); end
      n_checks++; if (h !== eh) begin n_errors++; $display("FAIL md_rand_hi op=%0d a=%h b=%h: got %h want %h", op, a, b, h, eh); end
      n_checks++; if (l !== el) begin n_errors++; $display("FAIL md_rand_lo op=%0d a=%h b=%h: got %h want %h", op, a, b, l, el); end
      exp_hi = eh; exp_lo = el;
    end
  endtask

  task automatic test_busy_ignore();
    int cyc, d; logic [31:0] h, l;
    run_md(3'd5, 32'h1111, 32'h0, d, h, l);
    run_md(3'd6, 32'h2222, 32'h0, d, h, l);
    srca = 32'd100; srcb = 32'd7; md_op = 3'd3; md_start = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (md_busy !== 1'b1) begin n_errors++; $display("FAIL busy_accept: got %b want 1", md_busy); end
    srca = 32'hDEAD; md_op = 3'd5;
    @(posedge clk); #1;
    n_checks++; if (hi !== 32'h1111) begin n_errors++; $display("FAIL busy_mthi_ignored: got %h want 00001111", hi); end
    srca = 32'd55; srcb = 32'd3; md_op = 3'd3;
    @(posedge clk); #1;
    n_checks++; if (lo !== 32'h2222) begin n_errors++; $display("FAIL busy_lo_hold: got %h want 00002222", lo); end
    md_start = 1'b0; md_op = 3'd0;
    cyc = 2;
    while (md_busy && cyc < 100) begin @(posedge clk); #1; cyc++; end
    n_checks++; if (cyc !== 10) begin n_errors++; $display("FAIL busy_div_len: got %0d want 10", cyc); end
    n_checks++; if (lo !== 32'd14 || hi !== 32'd2) begin n_errors++; $display("FAIL busy_div_result: got hi=%h lo=%h want hi=2 lo=14", hi, lo); end
    exp_hi = 32'd2; exp_lo = 32'd14;
    srca = 32'hABCD; md_op = 3'd6; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0; md_op = 3'd0;
    exp_lo = 32'hABCD;
    n_checks++; if (lo !== exp_lo) begin n_errors++; $display("FAIL mtlo: got %h want %h", lo, exp_lo); end
    n_checks++; if (md_busy !== 1'b0) begin n_errors++; $display("FAIL mtlo_busy: got %b want 0", md_busy); end
    alu_op = 4'd12; #1;
    n_checks++; if (alu_result !== exp_hi) begin n_errors++; $display("FAIL mfhi: got %h want %h", alu_result, exp_hi); end
    alu_op = 4'd13; #1;
    n_checks++; if (alu_result !== exp_lo) begin n_errors++; $display("FAIL mflo: got %h want %h", alu_result, exp_lo); end
  endtask

  task automatic test_back_to_back();
    int c1, c2; logic [31:0] h, l;
    run_md(3'd2, 32'd1000, 32'd1000, c1, h, l);
    run_md(3'd4, 32'd1000, 32'd30, c2, h, l);
    n_checks++; if (c1 !== 5 || c2 !== 10) begin n_errors++; $display("FAIL b2b_busy: got %0d,%0d want 5,10", c1, c2); end
    n_checks++; if (h !== 32'd10 || l !== 32'd33) begin n_errors++; $display("FAIL b2b_result: got hi=%h lo=%h want hi=a lo=21", h, l); end
    exp_hi = 32'd10; exp_lo = 32'd33;
  endtask

  task automatic test_reset_mid();
    int cyc, d; logic [31:0] h, l;
    run_md(3'd5, 32'h5555, 32'h0, d, h, l);
    srca = 32'd77; srcb = 32'd5; md_op = 3'd3; md_start = 1'b1;
    @(posedge clk); #1;
    md_start = 1'b0; md_op = 3'd0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (md_busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_prebusy: got %b want 1", md_busy); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_errors++; $display("FAIL rstmid_hilo: got hi=%h lo=%h want 0", hi, lo); end
    n_checks++; if (md_busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy: got %b want 0", md_busy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_md(3'd1, 32'd6, 32'hFFFF_FFF9, cyc, h, l);
    n_checks++; if (cyc !== 5) begin n_errors++; $display("FAIL rstmid_mult_busy: got %0d want 5", cyc); end
    n_checks++; if (h !== 32'hFFFF_FFFF || l !== 32'hFFFF_FFD6) begin n_errors++; $display("FAIL rstmid_mult: got hi=%h lo=%h want ffffffff/ffffffd6", h, l); end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_mdu_directed();
    test_mdu_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
